// File: rtl/burst_fetch_ctrl.sv
// Avalon-MM burst read master feeding a FWFT line FIFO with one frame of words, credit-limited to FIFO depth.
// Optional sticky underrun flag is built only when FETCH_UNDERRUN_DETECT_EN is defined.
module burst_fetch_ctrl #(
    parameter int ADDR_SIZE       = 32,
    parameter int DATA_SIZE       = 32,
    parameter int FIFO_PTR_DEPTH  = 9,
    parameter int BURST_LEN       = 16,
    parameter int BURSTCOUNT_SIZE = 5,
    parameter int FRAME_WORDS     = 307200
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START_IN,
    input  logic [ADDR_SIZE-1:0]       FRAME_BASE_IN,
    output logic [ADDR_SIZE-1:0]       AVM_ADDRESS_OUT,
    output logic                       AVM_READ_OUT,
    output logic [BURSTCOUNT_SIZE-1:0] AVM_BURSTCOUNT_OUT,
    input  logic                       AVM_WAITREQUEST_IN,
    input  logic                       AVM_READDATAVALID_IN,
    output logic                       FIFO_WR_OUT,
    output logic                       FIFO_FLUSH_OUT,
    input  logic                       FIFO_RD_IN,
    output logic                       BUSY_OUT,
    output logic                       DONE_OUT,
    output logic                       UNDERRUN_OUT
);
    localparam int DEPTH          = 1 << FIFO_PTR_DEPTH;
    localparam int CNT_W          = FIFO_PTR_DEPTH + 1;
    localparam int SUM_W          = FIFO_PTR_DEPTH + 2;
    localparam int WL_W           = $clog2(FRAME_WORDS + 1);
    localparam int BYTES_PER_WORD = DATA_SIZE / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [ADDR_SIZE-1:0]       addr_q, addr_d, base_q, base_d;
    logic [WL_W-1:0]            words_left_q, words_left_d;
    logic [CNT_W-1:0]           outstanding_q, outstanding_d;
    logic [CNT_W-1:0]           occupancy_q, occupancy_d;
    logic [BURSTCOUNT_SIZE-1:0] burst_q, burst_d, next_burst;
    logic                       read_q, read_d, flush_q, flush_d, done_q, done_d;
    logic [SUM_W-1:0]           committed_next;
    logic                       accept, wr_en, pop_en;

    function automatic logic [BURSTCOUNT_SIZE-1:0] burst_for(input logic [WL_W-1:0] left);
        if (int'(left) >= BURST_LEN) return BURSTCOUNT_SIZE'(BURST_LEN);
        return BURSTCOUNT_SIZE'(left);
    endfunction

    assign accept = read_q && !AVM_WAITREQUEST_IN;
    assign wr_en  = (state_q == ISSUE) && AVM_READDATAVALID_IN;
    assign pop_en = FIFO_RD_IN && (occupancy_q != '0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d        = state_q;
        addr_d         = addr_q;
        base_d         = base_q;
        words_left_d   = words_left_q;
        outstanding_d  = outstanding_q;
        occupancy_d    = occupancy_q + CNT_W'(wr_en) - CNT_W'(pop_en);
        burst_d        = burst_q;
        read_d         = 1'b0;
        flush_d        = 1'b0;
        done_d         = 1'b0;
        next_burst     = '0;
        committed_next = '0;

        if (accept) begin
            outstanding_d = outstanding_q + CNT_W'(burst_q);
            words_left_d  = words_left_q - WL_W'(burst_q);
            addr_d        = addr_q + ADDR_SIZE'(burst_q) * ADDR_SIZE'(BYTES_PER_WORD);
        end
        if (AVM_READDATAVALID_IN && state_q != IDLE)
            outstanding_d = outstanding_d - 1'b1;

        case (state_q)
            IDLE: if (START_IN) begin
                addr_d       = FRAME_BASE_IN;
                words_left_d = WL_W'(FRAME_WORDS);
                occupancy_d  = '0;
                flush_d      = 1'b1;
                state_d      = ISSUE;
            end
            ISSUE: if (START_IN) begin
                base_d  = FRAME_BASE_IN;
                state_d = DRAIN;
            end else if (words_left_d == '0 && outstanding_d == '0) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DRAIN: begin
                if (START_IN) base_d = FRAME_BASE_IN;
                // Old frame fully retired: the same-cycle START base wins over the held one.
                if (outstanding_q == '0 && !read_q) begin
                    addr_d       = START_IN ? FRAME_BASE_IN : base_q;
                    words_left_d = WL_W'(FRAME_WORDS);
                    occupancy_d  = '0;
                    flush_d      = 1'b1;
                    state_d      = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A stalled request stays frozen; new ones only start in a settled ISSUE, one flush cycle after entry.
        next_burst     = burst_for(words_left_d);
        committed_next = SUM_W'(outstanding_d) + SUM_W'(occupancy_d) + SUM_W'(next_burst);
        if (read_q && AVM_WAITREQUEST_IN) begin
            read_d = 1'b1;
        end else if (state_q == ISSUE && state_d == ISSUE && words_left_d != '0 &&
                     committed_next <= SUM_W'(DEPTH)) begin
            read_d  = 1'b1;
            burst_d = next_burst;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            base_q        <= '0;
            words_left_q  <= '0;
            outstanding_q <= '0;
            occupancy_q   <= '0;
            burst_q       <= '0;
            read_q        <= 1'b0;
            flush_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            base_q        <= base_d;
            words_left_q  <= words_left_d;
            outstanding_q <= outstanding_d;
            occupancy_q   <= occupancy_d;
            burst_q       <= burst_d;
            read_q        <= read_d;
            flush_q       <= flush_d;
            done_q        <= done_d;
        end
    end

    assign AVM_ADDRESS_OUT    = addr_q;
    assign AVM_READ_OUT       = read_q;
    assign AVM_BURSTCOUNT_OUT = burst_q;
    assign FIFO_WR_OUT        = wr_en;
    assign FIFO_FLUSH_OUT     = flush_q;
    assign BUSY_OUT           = (state_q != IDLE);
    assign DONE_OUT           = done_q;

`ifdef FETCH_UNDERRUN_DETECT_EN
    logic underrun_q;
    always_ff @(posedge CLK) begin
        if (RST || START_IN)
            underrun_q <= 1'b0;
        else if (FIFO_RD_IN && occupancy_q == '0 && state_q != IDLE)
            underrun_q <= 1'b1;
    end
    assign UNDERRUN_OUT = underrun_q;
`else
    assign UNDERRUN_OUT = 1'b0;
`endif

endmodule
